// File: rtl/prog_rom_loader_arb_pkg.sv
// Shared types and constants for the program ROM loader/arbiter.
// ROM index map: 0..4 = 1F,1H,1K,1L,1N.
package prog_rom_loader_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD
  } state_e;

  localparam int ROM_COUNT_DEF = 5;
  localparam int ROM_AW_DEF    = 13;

  localparam int IDX_1F = 0;
  localparam int IDX_1H = 1;
  localparam int IDX_1K = 2;
  localparam int IDX_1L = 3;
  localparam int IDX_1N = 4;

  localparam int CNT_W = 17;

  localparam int LOAD_BYTES =
    ROM_COUNT_DEF << ROM_AW_DEF;

  function automatic logic [CNT_W-1:0]
    load_bytes(input int n, input int aw);
    return CNT_W'(n << aw);
  endfunction

endpackage

// File: rtl/prog_rom_loader_arb.sv
// Program ROM access arbiter: HPS ioctl download vs 6502 fetch.
// Holds the CPU in reset around a load and flags a full-size image.
module prog_rom_loader_arb
  import prog_rom_loader_arb_pkg::*;
#(
  parameter int ROM_COUNT = ROM_COUNT_DEF,
  parameter int ROM_AW    = ROM_AW_DEF,
  parameter int RST_HOLD  = 16,
  parameter bit SKIP_LOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [15:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic                 ioctl_wait,
  input  logic [ROM_AW-1:0]    cpu_addr,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic [7:0]           rom_wdata,
  output logic [ROM_COUNT-1:0] rom_we,
  output logic                 cpu_reset_n,
  output logic                 loaded,
  output logic [7:0]           load_sum
);

  localparam int IDX_W = 16 - ROM_AW;
  localparam logic [CNT_W-1:0] FULL =
    load_bytes(ROM_COUNT, ROM_AW);
  localparam logic [7:0] HOLD_INIT =
    8'(RST_HOLD);

  state_e               state_q, state_d;
  logic                 dl_q, dl_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           sum_q, sum_d;
  logic                 loaded_q, loaded_d;
  logic [7:0]           hold_q, hold_d;
  logic [ROM_AW-1:0]    addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [ROM_COUNT-1:0] we_q, we_d;
  logic                 wait_q, wait_d;
  logic                 crst_q, crst_d;

  logic [IDX_W-1:0]     idx;
  logic                 idx_ok;
  logic                 acc;
  logic [ROM_COUNT-1:0] dec;
  logic [CNT_W-1:0]     cnt_inc;

  assign idx    = ioctl_addr[15:ROM_AW];
  assign idx_ok = int'(idx) < ROM_COUNT;
  // A strobe is only honoured inside the window and when not stalled.
  assign acc    = ioctl_download && ioctl_wr
                  && !wait_q;

  always_comb begin
    dec = '0;
    for (int i = 0; i < ROM_COUNT; i++)
      dec[i] = (int'(idx) == i);
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q
                                 : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    dl_d     = ioctl_download;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    loaded_d = loaded_q;
    hold_d   = hold_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = '0;
    wait_d   = 1'b0;
    crst_d   = crst_q;
    unique case (state_q)
      ST_RUN: begin
        crst_d = 1'b1;
        if (ioctl_download && !dl_q) begin
          state_d  = ST_LOAD;
          crst_d   = 1'b0;
          cnt_d    = '0;
          sum_d    = '0;
          loaded_d = 1'b0;
        end
      end
      ST_LOAD: begin
        crst_d = 1'b0;
        if (acc) begin
          state_d = ST_WRITE;
          wait_d  = 1'b1;
          addr_d  = ioctl_addr[ROM_AW-1:0];
          wdata_d = ioctl_dout;
          if (idx_ok) begin
            we_d  = dec;
            cnt_d = cnt_inc;
            sum_d = sum_q + ioctl_dout;
          end
        end else if (!ioctl_download) begin
          state_d  = ST_HOLD;
          hold_d   = HOLD_INIT;
          loaded_d = (cnt_q == FULL);
        end
      end
      ST_WRITE: begin
        state_d = ST_LOAD;
      end
      ST_HOLD: begin
        crst_d = 1'b0;
        if (ioctl_download) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          sum_d    = '0;
          loaded_d = 1'b0;
        end else if (hold_q <= 8'd1) begin
          state_d = ST_RUN;
          crst_d  = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HOLD;
      dl_q     <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      loaded_q <= SKIP_LOAD;
      hold_q   <= HOLD_INIT;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      wait_q   <= 1'b0;
      crst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dl_q     <= dl_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      loaded_q <= loaded_d;
      hold_q   <= hold_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      wait_q   <= wait_d;
      crst_q   <= crst_d;
    end
  end

  // CPU owns the ROM address bus only while running.
  assign rom_addr    = (state_q == ST_RUN) ? cpu_addr
                                           : addr_q;
  assign rom_wdata   = wdata_q;
  assign rom_we      = we_q;
  assign ioctl_wait  = wait_q;
  assign cpu_reset_n = crst_q;
  assign loaded      = loaded_q;
  assign load_sum    = sum_q;

endmodule

// File: tb/tb_prog_rom_loader_arb.sv
// Randomized bench for prog_rom_loader_arb with a byte-level model.
// Uses 2 KB images so full loads stay short.
module tb_prog_rom_loader_arb;

  localparam int RC   = 5;
  localparam int AW   = 11;
  localparam int RH   = 16;
  localparam int FULL = RC << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [15:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait;
  logic [AW-1:0] cpu_addr = '0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_wdata;
  logic [RC-1:0] rom_we;
  logic          cpu_reset_n;
  logic          loaded;
  logic [7:0]    load_sum;

  prog_rom_loader_arb #(
    .ROM_COUNT(RC),
    .ROM_AW(AW),
    .RST_HOLD(RH),
    .SKIP_LOAD(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .cpu_addr(cpu_addr),
    .rom_addr(rom_addr),
    .rom_wdata(rom_wdata),
    .rom_we(rom_we),
    .cpu_reset_n(cpu_reset_n),
    .loaded(loaded),
    .load_sum(load_sum)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         m_cnt = 0;
  logic [7:0] m_sum = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [15:0] a,
                         input logic [7:0] d);
    int            idx;
    logic [RC-1:0] ewe;
    idx = int'(a) >> AW;
    ewe = '0;
    if (idx < RC) begin
      ewe[idx] = 1'b1;
      m_cnt++;
      m_sum += d;
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    chk("wait_hi", ioctl_wait, 1);
    chk("we", rom_we, ewe);
    if (idx < RC) begin
      chk("waddr", rom_addr,
          int'(a) % (1 << AW));
      chk("wdata", rom_wdata, d);
    end
    step();
    chk("wait_lo", ioctl_wait, 0);
    chk("we_off", rom_we, 0);
  endtask

  task automatic begin_load();
    ioctl_download = 1'b1;
    step();
    m_cnt = 0;
    m_sum = '0;
    chk("ld_cpu_rst", cpu_reset_n, 0);
    chk("ld_loaded", loaded, 0);
    chk("ld_sum", load_sum, 0);
  endtask

  task automatic end_load(input string tag);
    int n;
    ioctl_download = 1'b0;
    step();
    chk({tag, "_loaded"}, loaded,
        32'(m_cnt == FULL));
    chk({tag, "_sum"}, load_sum, m_sum);
    chk({tag, "_rst"}, cpu_reset_n, 0);
    n = 0;
    while (cpu_reset_n !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_hold"}, n, RH);
  endtask

  task automatic run_check();
    for (int i = 0; i < 8; i++) begin
      cpu_addr = AW'($urandom);
      #1;
      chk("run_mux", rom_addr, cpu_addr);
    end
    ioctl_addr = 16'h0010;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    chk("run_wr_wait", ioctl_wait, 0);
    chk("run_wr_we", rom_we, 0);
    chk("run_cpu", cpu_reset_n, 1);
  endtask

  task automatic load_seq(input int nbytes,
                          input bit rnd_data);
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < nbytes; i++) begin
      a = 16'(i);
      d = rnd_data ? 8'($urandom) : a[7:0];
      wr_byte(a, d);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  d;
    logic [7:0]  e;

    repeat (3) step();
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_we", rom_we, 0);
    chk("rst_wdata", rom_wdata, 0);
    chk("rst_cpu", cpu_reset_n, 0);
    chk("rst_sum", load_sum, 0);
    chk("rst_loaded", loaded, 0);
    reset_n = 1'b1;
    n = 0;
    while (cpu_reset_n !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("rst_hold", n, RH);
    chk("rst_loaded2", loaded, 0);
    run_check();

    begin_load();
    for (int i = 0; i < FULL; i++) begin
      a = 16'(i);
      wr_byte(a, a[7:0]);
      if (i == FULL / 2) begin
        wr_byte(16'hA000, 8'($urandom));
        wr_byte(16'hFFFF, 8'($urandom));
      end
    end
    end_load("full");
    chk("full_sum0", load_sum, 0);
    chk("full_flag", loaded, 1);
    run_check();

    begin_load();
    for (int i = 0; i < 'h400; i++) begin
      a = 16'($urandom_range(0, FULL - 1));
      wr_byte(a, 8'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    end_load("abort");
    run_check();

    begin_load();
    a = 16'($urandom_range(0, (1 << AW) - 1));
    b = 16'((3 << AW) + 5);
    d = 8'($urandom);
    e = d + 8'h5A;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    step();
    m_cnt++;
    m_sum += d;
    chk("dbl_wait1", ioctl_wait, 1);
    chk("dbl_we1", rom_we, 1);
    ioctl_addr = b;
    ioctl_dout = e;
    step();
    ioctl_wr = 1'b0;
    chk("dbl_wait2", ioctl_wait, 0);
    chk("dbl_we2", rom_we, 0);
    step();
    chk("dbl_wait3", ioctl_wait, 0);
    chk("dbl_we3", rom_we, 0);
    for (int i = 0; i < 6; i++)
      wr_byte(16'($urandom_range(0, FULL - 1)),
              8'($urandom));
    end_load("dbl");

    begin_load();
    load_seq(FULL / 2, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_wait", ioctl_wait, 0);
    chk("mid_we", rom_we, 0);
    chk("mid_wdata", rom_wdata, 0);
    chk("mid_cpu", cpu_reset_n, 0);
    chk("mid_sum", load_sum, 0);
    chk("mid_loaded", loaded, 0);
    step();
    reset_n = 1'b1;
    begin_load();
    load_seq(FULL, 1'b1);
    end_load("reload");
    chk("reload_flag", loaded, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
